wb_master: RTL and testbench
============================

# wb_master

Wishbone classic-cycle bus master that, on an interrupt request, copies a block of `COUNT` words from a source region to a destination region on the same bus. Each word is transferred as a read cycle followed immediately by a write cycle. It sits between an interrupt source and the shared Wishbone interconnect as a minimal autonomous copy engine. All outputs are registered.

## Interface
- `AW`, default 8, address width (ADR_O).
- `DW`, default 8, data width (DAT_I, DAT_O).
- `SW`, default 1, select width (SEL_O).
- `SRC_BASE`, default 8'h00, first read address.
- `DST_BASE`, default 8'h80, first write address.
- `COUNT`, default 4, words per transfer (≥1).
- `TIMEOUT`, default 16, maximum wait cycles per bus phase; 0 disables the timeout.

Ports:
- `CLK_I`  in  1  single clock; everything is synchronous to its rising edge.
- `RST_I`  in  1  synchronous, active-high reset.
- `ADR_O`  out  AW  bus address.
- `DAT_O`  out  DW  write data.
- `WE_O`  out  1  write enable (1 = write, 0 = read).
- `SEL_O`  out  SW  byte select.
- `STB_O`  out  1  strobe.
- `CYC_O`  out  1  bus cycle in progress.
- `DAT_I`  in  DW  read data; sampled only on an ACK_I edge in READ.
- `ACK_I`  in  1  slave acknowledge.
- `ERR_I`  in  1  slave error.
- `INTR_I`  in  1  transfer request, level-sensitive.

## Operation
- The state machine has three states: IDLE, READ and WRITE. An internal word index `idx` runs from 0 to COUNT-1. An internal data register `buf` holds the last word read.
- **IDLE**
  - Outputs: CYC_O=STB_O=WE_O=0, ADR_O=0, DAT_O=0, SEL_O=0.
  - If INTR_I=1 at an edge: set idx=0 and go to READ.
- **READ**
  - Outputs: CYC_O=STB_O=1, WE_O=0, SEL_O=all ones, ADR_O=SRC_BASE+idx (mod 2^AW), DAT_O holds its previous value.
  - On an edge with ERR_I=1: go to IDLE (abort).
  - Else, on an edge with ACK_I=1: capture DAT_I into buf and go to WRITE.
  - Else: hold.
- **WRITE**
  - Outputs: CYC_O=STB_O=WE_O=1, SEL_O=all ones, ADR_O=DST_BASE+idx (mod 2^AW), DAT_O=buf.
  - On an edge with ERR_I=1: go to IDLE.
  - Else, on an edge with ACK_I=1: if idx=COUNT-1, go to IDLE; otherwise increment idx and go to READ.
- **Priority:** ERR_I beats ACK_I when both are high. An abort discards the remaining words and reports no status.
- **Timeout:** a wait counter clears on every state entry and increments each cycle in READ or WRITE without ACK_I or ERR_I. When it reaches TIMEOUT, the block aborts to IDLE exactly as on ERR_I.
- INTR_I is ignored while in READ or WRITE. Because the request is level-sensitive, if INTR_I is still high in IDLE a new transfer starts (idx reset to 0).
- **Address wrap:** base+idx wraps modulo 2^AW with no error.
- **Reset:** RST_I=1 at any edge forces IDLE, idx=0, buf=0, wait counter=0 and all outputs to 0 after that edge. This holds mid-cycle as well: CYC_O drops without waiting for ACK_I.

## Timing
- Every output changes only on a CLK_I rising edge.
- Request latency: INTR_I=1 at edge k gives CYC_O=STB_O=1 with the READ address after edge k (1 cycle).
- Fastest phase: ACK_I held high gives one cycle per phase, so a word takes 2 cycles.
- CYC_O stays high continuously across all READ/WRITE phases of one transfer, and STB_O stays high with no idle gap between phases.
- A COUNT-word transfer with zero-wait slaves keeps CYC_O high for exactly 2·COUNT cycles.
- After completion or abort, CYC_O=STB_O=0 for at least 1 cycle (IDLE) before any new transfer.
- Timeout abort: with no response, CYC_O falls after TIMEOUT+1 cycles in the phase.

## Test plan
- **Idle hold:** reset, then INTR_I=0, ACK_I=0, ERR_I=0, DAT_I=8'hF0 for 50 cycles → CYC_O, STB_O, WE_O, ADR_O, DAT_O and SEL_O all stay 0.
- **Single word:** COUNT=1, pulse INTR_I, ACK_I tied high, DAT_I=8'hF0 →
  - cycle 1: read at 8'h00;
  - cycle 2: write at 8'h80 with DAT_O=8'hF0 and WE_O=1;
  - cycle 3: CYC_O=0.
- **Block with waits:** COUNT=4, ACK_I asserted 2 cycles after each STB_O rise or phase change, DAT_I=idx+8'h10 → writes of 8'h10..8'h13 to 8'h80..8'h83, in strict read/write order.
- **Error abort:** assert ERR_I together with ACK_I during the second READ → buf is not updated, CYC_O=0 the next cycle, and no further writes occur.
- **Timeout:** TIMEOUT=16, never ACK → CYC_O falls after 17 cycles. Holding INTR_I high restarts after 1 idle cycle at SRC_BASE.
- **Reset mid-transfer and wrap:** assert RST_I during WRITE → all outputs are 0 next cycle. Separately, set SRC_BASE=8'hFE, COUNT=4 → read addresses are FE, FF, 00, 01.

Source files
------------

// File: rtl/wb_master.sv
// Wishbone classic-cycle copy engine: on an interrupt request, copies COUNT
// words from SRC_BASE.. to DST_BASE.., one read cycle then one write cycle per
// word. Every output is driven straight from a flop.
module wb_master #(
  parameter int            AW       = 8,
  parameter int            DW       = 8,
  parameter int            SW       = 1,
  parameter logic [AW-1:0] SRC_BASE = 8'h00,
  parameter logic [AW-1:0] DST_BASE = 8'h80,
  parameter int            COUNT    = 4,
  parameter int            TIMEOUT  = 16
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  output logic [AW-1:0] ADR_O,
  output logic [DW-1:0] DAT_O,
  output logic          WE_O,
  output logic [SW-1:0] SEL_O,
  output logic          STB_O,
  output logic          CYC_O,
  input  logic [DW-1:0] DAT_I,
  input  logic          ACK_I,
  input  logic          ERR_I,
  input  logic          INTR_I
);

  localparam int IW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [IW-1:0] LAST_IDX  = IW'(COUNT - 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] buf_q, buf_d;
  logic [TW-1:0] wait_q, wait_d;

  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          we_q, we_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          stb_q, stb_d;
  logic          cyc_q, cyc_d;

  logic          timed_out;
  logic          abort;

  // Phase sequencing: ERR_I or an expired wait counter aborts, else ACK_I advances.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    timed_out = (TIMEOUT != 0) && (wait_q == TMO_LIMIT);
    abort     = ERR_I || timed_out;

    case (state_q)
      S_IDLE: begin
        if (INTR_I) begin
          idx_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (ACK_I) begin
          buf_d   = DAT_I;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (ACK_I) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_READ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Wait counter: cleared on every state entry, counts unanswered bus cycles.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if ((TIMEOUT != 0) && (state_q != S_IDLE) && !ACK_I && !ERR_I) begin
      wait_d = wait_q + TW'(1);
    end
  end

  // Bus outputs for the state being entered, so they appear right after the edge.
  always_comb begin
    adr_d = '0;
    dat_d = '0;
    we_d  = 1'b0;
    sel_d = '0;
    stb_d = 1'b0;
    cyc_d = 1'b0;
    case (state_d)
      S_READ: begin
        adr_d = SRC_BASE + AW'(idx_d);
        dat_d = dat_q;
        sel_d = '1;
        stb_d = 1'b1;
        cyc_d = 1'b1;
      end
      S_WRITE: begin
        adr_d = DST_BASE + AW'(idx_d);
        dat_d = buf_d;
        we_d  = 1'b1;
        sel_d = '1;
        stb_d = 1'b1;
        cyc_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK_I) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (RST_I) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
      wait_q  <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      stb_q   <= 1'b0;
      cyc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      wait_q  <= wait_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      stb_q   <= stb_d;
      cyc_q   <= cyc_d;
    end
  end

  assign ADR_O = adr_q;
  assign DAT_O = dat_q;
  assign WE_O  = we_q;
  assign SEL_O = sel_q;
  assign STB_O = stb_q;
  assign CYC_O = cyc_q;

endmodule

// File: tb/tb_wb_master.sv
// Bench for wb_master: a reactive Wishbone slave with random wait states,
// error and stall injection, a scoreboard of expected bus phases and a
// monitor that pops and compares each completed or aborted phase.
module tb_wb_master;

  localparam logic [7:0] SRC     = 8'h00;
  localparam logic [7:0] DST     = 8'h80;
  localparam int         COUNT   = 4;
  localparam int         TIMEOUT = 16;

  typedef enum logic [1:0] {K_ACK, K_ERR, K_TMO} kind_e;
  typedef struct {
    kind_e      kind;
    logic       we;
    logic [7:0] adr;
    logic [7:0] dat;
    bit         last;
  } exp_t;
  typedef struct {
    int mode;   // 0 normal, 1 error, 2 stall (timeout)
    int phase;  // phase index (0..2*COUNT-1) that misbehaves
    int waits;  // fixed wait cycles per phase, or -1 for random 0..3
  } plan_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, intr, ack, err;
  logic [7:0] dat_i;
  logic [7:0] adr_o, dat_o;
  logic       we_o, stb_o, cyc_o;
  logic [0:0] sel_o;
  logic [19:0] outs;
  assign outs = {cyc_o, stb_o, we_o, sel_o, adr_o, dat_o};

  // Second stimulus group for the single-word and wrapping instances.
  logic       intr2, ack2, err2;
  logic [7:0] dat2;
  logic [7:0] one_adr, one_dat, wr_adr, wr_dat;
  logic       one_we, one_stb, one_cyc, wr_we, wr_stb, wr_cyc;
  logic [0:0] one_sel, wr_sel;
  logic [19:0] one_outs, wr_outs;
  assign one_outs = {one_cyc, one_stb, one_we, one_sel, one_adr, one_dat};
  assign wr_outs  = {wr_cyc, wr_stb, wr_we, wr_sel, wr_adr, wr_dat};

  wb_master #(.COUNT(COUNT), .TIMEOUT(TIMEOUT)) dut (
    .CLK_I(clk), .RST_I(rst), .ADR_O(adr_o), .DAT_O(dat_o), .WE_O(we_o),
    .SEL_O(sel_o), .STB_O(stb_o), .CYC_O(cyc_o), .DAT_I(dat_i),
    .ACK_I(ack), .ERR_I(err), .INTR_I(intr)
  );

  wb_master #(.COUNT(1)) u_one (
    .CLK_I(clk), .RST_I(rst), .ADR_O(one_adr), .DAT_O(one_dat), .WE_O(one_we),
    .SEL_O(one_sel), .STB_O(one_stb), .CYC_O(one_cyc), .DAT_I(dat2),
    .ACK_I(ack2), .ERR_I(err2), .INTR_I(intr2)
  );

  wb_master #(.SRC_BASE(8'hFE), .DST_BASE(8'hFF), .COUNT(4)) u_wrap (
    .CLK_I(clk), .RST_I(rst), .ADR_O(wr_adr), .DAT_O(wr_dat), .WE_O(wr_we),
    .SEL_O(wr_sel), .STB_O(wr_stb), .CYC_O(wr_cyc), .DAT_I(dat2),
    .ACK_I(ack2), .ERR_I(err2), .INTR_I(intr2)
  );

  logic [7:0] mem [256];
  exp_t       exp_q [$];
  plan_t      plan_q [$];
  int         vectors = 0;
  int         miscompares = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic rand_mem();
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
  endtask

  // Reference: word i is read from SRC+i then written to DST+i with the value
  // read; DAT_O during a read still shows the previous write data (0 at start).
  task automatic push_transfer(int mode, int phase);
    exp_t e;
    int   i;
    for (int p = 0; p < 2 * COUNT; p++) begin
      i      = p / 2;
      e.we   = (p % 2) == 1;
      e.adr  = e.we ? 8'(DST + i) : 8'(SRC + i);
      e.dat  = e.we ? mem[8'(SRC + i)] : ((i == 0) ? 8'h00 : mem[8'(SRC + i - 1)]);
      e.kind = K_ACK;
      e.last = (p == 2 * COUNT - 1);
      if (mode != 0 && p == phase) begin
        e.kind = (mode == 1) ? K_ERR : K_TMO;
        e.last = 1'b1;
      end
      exp_q.push_back(e);
      if (e.last) break;
    end
  endtask

  task automatic pop_cmp(kind_e k, logic we, logic [7:0] adr, logic [7:0] dat, output bit last);
    exp_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_phase: got kind %0d we %0b adr %0h, expected no phase", k, we, adr);
      last = 1'b1;
    end else begin
      e = exp_q.pop_front();
      check("bus_phase", {k, we, adr, dat}, {e.kind, e.we, e.adr, e.dat});
      last = e.last;
    end
  endtask

  // Reactive slave: answers each phase after its planned wait, or injects a fault.
  initial begin
    bit    pa, pr, fault;
    int    cnt, ph, wt;
    plan_t pl;
    pa = 0; pr = 0; cnt = 0; ph = -1; wt = 0;
    pl = '{0, 0, -1};
    forever begin
      @(posedge clk);
      #1;
      if (rst || !cyc_o) begin
        ack = 1'b0; err = 1'b0; dat_i = 8'hF0; pa = 0; pr = 0;
      end else begin
        if (!pa) begin
          ph = -1;
          if (plan_q.size() > 0) pl = plan_q.pop_front();
          else pl = '{0, 0, -1};
        end
        if (!pa || pr) begin
          ph++;
          cnt = 0;
          wt = (pl.waits < 0) ? int'($urandom_range(0, 3)) : pl.waits;
        end else begin
          cnt++;
        end
        dat_i = we_o ? 8'($urandom) : mem[adr_o];
        fault = (pl.mode != 0) && (ph == pl.phase);
        if (fault && pl.mode == 2) begin
          ack = 1'b0; err = 1'b0;
        end else if (fault) begin
          ack = (cnt >= wt); err = (cnt >= wt);
        end else begin
          ack = (cnt >= wt); err = 1'b0;
        end
        pa = 1;
        pr = ack || err;
      end
    end
  end

  // Monitor: pops one expectation per answered phase, or per silent abort.
  initial begin
    bit         prev_cyc, prev_resp, last, exp_idle;
    int         stall;
    logic       lw;
    logic [7:0] la, ld;
    prev_cyc = 0; prev_resp = 0; exp_idle = 0; stall = 0;
    lw = 1'b0; la = '0; ld = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_cyc = 0; prev_resp = 0; exp_idle = 0; stall = 0;
      end else begin
        if (exp_idle) begin
          check("post_idle", outs, 0);
          exp_idle = 0;
        end
        if (cyc_o) begin
          lw = we_o; la = adr_o; ld = dat_o;
          if (ack || err) begin
            pop_cmp(err ? K_ERR : K_ACK, we_o, adr_o, dat_o, last);
            exp_idle = last;
            stall = 0;
            prev_resp = 1;
          end else begin
            stall++;
            prev_resp = 0;
          end
        end else if (prev_cyc && !prev_resp) begin
          pop_cmp(K_TMO, lw, la, ld, last);
          check("timeout_len", stall, TIMEOUT + 1);
          check("abort_idle", outs, 0);
          stall = 0;
        end
        prev_cyc = cyc_o;
      end
    end
  end

  task automatic wait_idle();
    for (int n = 0; n < 400 && cyc_o; n++) begin
      @(posedge clk);
      #1;
    end
    check("done_in_budget", cyc_o, 0);
  endtask

  task automatic run_transfer(int mode, int phase, int waits, output int len);
    plan_q.push_back('{mode, phase, waits});
    push_transfer(mode, phase);
    @(posedge clk); #1 intr = 1'b1;
    @(posedge clk); #1 intr = 1'b0;
    check("req_latency", {cyc_o, stb_o, we_o, adr_o}, {3'b110, SRC});
    len = cyc_o ? 1 : 0;
    for (int n = 0; n < 400 && cyc_o; n++) begin
      @(posedge clk);
      #1;
      if (cyc_o) len++;
    end
    check("done_in_budget", cyc_o, 0);
  endtask

  initial begin
    int         len, r, mode;
    int         p, i;
    logic       we;
    logic [19:0] exp_w, exp_o;

    rst = 1'b1; intr = 1'b0; ack = 1'b0; err = 1'b0; dat_i = 8'hF0;
    intr2 = 1'b0; ack2 = 1'b1; err2 = 1'b0; dat2 = 8'hF0;
    rand_mem();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs, 0);
    rst = 1'b0;

    // Idle hold with no request.
    repeat (50) begin
      @(posedge clk);
      #1;
      check("idle_hold", outs, 0);
    end

    // Block with two wait cycles per phase, data idx+8'h10.
    for (int k = 0; k < COUNT; k++) mem[8'(SRC + k)] = 8'(8'h10 + k);
    run_transfer(0, 0, 2, len);
    check("waited_len", len, 2 * COUNT * 3);

    // Zero-wait slave: CYC_O high for exactly 2*COUNT cycles.
    rand_mem();
    run_transfer(0, 0, 0, len);
    check("zero_wait_len", len, 2 * COUNT);

    // ERR_I with ACK_I during the second read aborts before any further write.
    rand_mem();
    run_transfer(1, 2, -1, len);

    // Stall in the first read; INTR_I held so a new transfer follows one idle cycle.
    rand_mem();
    plan_q.push_back('{2, 0, -1});
    push_transfer(2, 0);
    plan_q.push_back('{0, 0, -1});
    push_transfer(0, 0);
    @(posedge clk); #1 intr = 1'b1;
    @(posedge clk); #1;
    check("tmo_latency", {cyc_o, adr_o}, {1'b1, SRC});
    len = 1;
    for (int n = 0; n < 100 && cyc_o; n++) begin
      @(posedge clk);
      #1;
      if (cyc_o) len++;
    end
    check("tmo_len", len, TIMEOUT + 1);
    @(posedge clk); #1;
    check("tmo_restart", {cyc_o, stb_o, we_o, adr_o}, {3'b110, SRC});
    intr = 1'b0;
    wait_idle();

    // Randomized transfers mixing clean runs, errors and stalls.
    repeat (24) begin
      rand_mem();
      r = int'($urandom_range(0, 9));
      mode = (r < 6) ? 0 : ((r < 8) ? 1 : 2);
      run_transfer(mode, int'($urandom_range(0, 2 * COUNT - 1)), -1, len);
    end

    // Reset during a write phase clears every output after the edge.
    rand_mem();
    plan_q.push_back('{0, 0, 1});
    push_transfer(0, 0);
    @(posedge clk); #1 intr = 1'b1;
    @(posedge clk); #1 intr = 1'b0;
    for (int n = 0; n < 50 && !we_o; n++) begin
      @(posedge clk);
      #1;
    end
    check("reached_write", we_o, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_mid_write", outs, 0);
    rst = 1'b0;
    exp_q.delete();
    plan_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("after_reset_idle", outs, 0);

    // Single-word instance and wrapping-address instance, ACK tied high.
    @(posedge clk); #1 intr2 = 1'b1;
    @(posedge clk); #1 intr2 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      p  = c - 1;
      i  = p / 2;
      we = (p % 2) == 1;
      if (c <= 8) begin
        exp_w = {1'b1, 1'b1, we, 1'b1,
                 we ? 8'(8'hFF + i) : 8'(8'hFE + i),
                 we ? 8'hF0 : ((i == 0) ? 8'h00 : 8'hF0)};
      end else begin
        exp_w = '0;
      end
      if (c == 1)      exp_o = {4'b1101, 8'h00, 8'h00};
      else if (c == 2) exp_o = {4'b1111, 8'h80, 8'hF0};
      else             exp_o = '0;
      check("wrap_cycle", wr_outs, exp_w);
      check("single_cycle", one_outs, exp_o);
      @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
